mem_access_master: RTL

M-stage memory access initiator for the pipelined MIPS core. Converts a load/store in the M stage into a request/grant/response transaction on the data-memory bus. Generates byte enables and lane-replicated store data, and sign- or zero-extends load data. Stalls the pipeline until the access completes and flags misaligned or out-of-range addresses without issuing a bus access.

---
 rtl/mem_access_master.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_master.sv
// ============================================================================
// Module   : mem_access_master
// Purpose  : M-stage load/store initiator on a req/gnt/rvalid data bus with
//            byte lanes, load extension, stall and address-error reporting.
//            Optional STORE_LOG_EN macro enables a simulation store log.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_master #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        M_Valid,
    input  logic [2:0]  M_MemOp,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WriteData,
    input  logic [31:0] M_PC,
    output logic        M_Stall,
    output logic [31:0] M_LoadData,
    output logic        M_LoadValid,
    output logic        M_AddrErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic        bus_we_q;

    logic        w_misalign;
    logic        w_illegal;
    logic        w_is_store;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_load_q;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // ---------------- request decode ----------------
    assign w_is_store = (M_MemOp >= OP_SW);

    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = M_WriteData;
        case (M_MemOp)
            OP_LW, OP_SW:         w_misalign = (M_Addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: w_misalign = M_Addr[0];
            default:              w_misalign = 1'b0;
        endcase
        case (M_MemOp)
            OP_SH: begin
                w_be    = M_Addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{M_WriteData[15:0]}};
            end
            OP_SB: begin
                w_be    = 4'b0001 << M_Addr[1:0];
                w_wdata = {4{M_WriteData[7:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = M_WriteData;
            end
        endcase
    end

    assign w_illegal = w_misalign | (M_Addr >= ADDR_LIMIT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (M_Valid) state_d = w_illegal ? S_DONE : S_REQ;
            S_REQ:  if (bus_gnt) state_d = bus_we_q ? S_DONE : S_RESP;
            S_RESP: if (bus_rvalid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q        <= 3'b000;
            off_q       <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            bus_we_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && M_Valid) begin
                op_q  <= M_MemOp;
                off_q <= M_Addr[1:0];
                err_q <= w_illegal;
                // Illegal accesses never reach the bus, so its fields are left alone
                if (!w_illegal) begin
                    bus_addr_q  <= {M_Addr[31:2], 2'b00};
                    bus_be_q    <= w_be;
                    bus_wdata_q <= w_wdata;
                    bus_we_q    <= w_is_store;
                end
            end
            if (state_q == S_RESP && bus_rvalid) rdata_q <= bus_rdata;
        end
    end

    // ---------------- load extraction ----------------
    assign w_load_q = (op_q < OP_SW);
    assign w_half   = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        case (off_q)
            2'd0:    w_byte = rdata_q[7:0];
            2'd1:    w_byte = rdata_q[15:8];
            2'd2:    w_byte = rdata_q[23:16];
            default: w_byte = rdata_q[31:24];
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus_req     = (state_q == S_REQ);
        M_Stall     = M_Valid & (state_q != S_DONE);
        M_AddrErr   = (state_q == S_DONE) & err_q;
        M_LoadValid = (state_q == S_DONE) & ~err_q & w_load_q;
        M_LoadData  = 32'd0;
        if (M_LoadValid) begin
            case (op_q)
                OP_LH:   M_LoadData = {{16{w_half[15]}}, w_half};
                OP_LHU:  M_LoadData = {16'd0, w_half};
                OP_LB:   M_LoadData = {{24{w_byte[7]}}, w_byte};
                OP_LBU:  M_LoadData = {24'd0, w_byte};
                default: M_LoadData = rdata_q;
            endcase
        end
    end

    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

`ifdef STORE_LOG_EN
    logic [31:0] w_log_data;
    assign w_log_data = bus_wdata_q & {{8{bus_be_q[3]}}, {8{bus_be_q[2]}},
                                       {8{bus_be_q[1]}}, {8{bus_be_q[0]}}};

    always @(posedge Clk) begin
        if (!Reset && state_q == S_REQ && bus_gnt && bus_we_q)
            $display("%d@%h: *%h <= %h", $time, M_PC, bus_addr_q, w_log_data);
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^M_PC;
`endif

endmodule

`default_nettype wire
